// File: rtl/alu_hs_if.sv
// Operand/result handshake bundle for alu_hs.
// The master side issues operations and consumes results.
interface alu_hs_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       csig;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             z;
  logic             n;
  logic             v;
  logic             c;

  modport master (
    output in_valid, a, b, csig, out_ready,
    input  in_ready, out_valid, out, z, n, v, c
  );

  modport slave (
    input  in_valid, a, b, csig, out_ready,
    output in_ready, out_valid, out, z, n, v, c
  );
endinterface

// File: rtl/alu_hs.sv
// Handshaked ALU: single-cycle ops plus a shift-add MUL
// that retires one multiplier bit per cycle.
module alu_hs #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  alu_hs_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam int M   = WIDTH - 1;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0]   r_out;
  logic               r_z;
  logic               r_n;
  logic               r_v;
  logic               r_c;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;

  logic             in_fire;
  logic             out_fire;
  logic             is_mul;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] res;
  logic             res_v;
  logic             res_c;

  assign bus.in_ready = rst_n &
    ((state == IDLE) |
     ((state == DONE) & bus.out_ready));
  assign bus.out_valid = (state == DONE);
  assign bus.out = r_out;
  assign bus.z   = r_z;
  assign bus.n   = r_n;
  assign bus.v   = r_v;
  assign bus.c   = r_c;

  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign is_mul   = (bus.csig == OP_MUL);

  assign sh   = bus.b[SHW-1:0];
  assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff = {1'b0, bus.a} - {1'b0, bus.b};

  always_comb begin
    res   = '0;
    res_v = 1'b0;
    res_c = 1'b0;
    unique case (bus.csig)
      4'd0: res = bus.a | bus.b;
      4'd1: res = bus.a & bus.b;
      4'd2: res = bus.a ^ bus.b;
      4'd3: res = bus.a << sh;
      4'd4: res = bus.a >> sh;
      4'd5: begin
        res   = diff[M:0];
        res_c = diff[WIDTH];
        res_v = (bus.a[M] != bus.b[M]) &
                (diff[M] != bus.a[M]);
      end
      4'd6: begin
        res   = sum[M:0];
        res_c = sum[WIDTH];
        res_v = (bus.a[M] == bus.b[M]) &
                (sum[M] != bus.a[M]);
      end
      4'd7: res = ~(bus.a | bus.b);
      4'd8: res = ~(bus.a & bus.b);
      4'd9: res = WIDTH'(
        $signed(bus.a) < $signed(bus.b));
      4'd10, 4'd11: res = '0;
      4'd12: res = '1;
      4'd13: res = bus.a + (bus.b << 2);
      4'd14: res = $signed(bus.a) >>> sh;
      4'd15: res = bus.a & ~bus.b;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE),
      (state == DONE): begin
        if (in_fire)
          state_nx = is_mul ? BUSY : DONE;
        else if (out_fire)
          state_nx = IDLE;
      end
      (state == BUSY): begin
        if (cnt == '0)
          state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_z    <= 1'b0;
      r_n    <= 1'b0;
      r_v    <= 1'b0;
      r_c    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (in_fire) begin
      if (is_mul) begin
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, bus.a};
        mplier <= bus.b;
        cnt    <= CW'(WIDTH);
      end else begin
        r_out <= res;
        r_z   <= (res == '0);
        r_n   <= res[M];
        r_v   <= res_v;
        r_c   <= res_c;
      end
    end else if (state == BUSY) begin
      if (cnt != '0) begin
        if (mplier[0])
          acc <= acc + mcand;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - 1'b1;
      end else begin
        // extra cycle publishes the product and its flags
        r_out <= acc[M:0];
        r_z   <= (acc[M:0] == '0);
        r_n   <= acc[M];
        r_v   <= |acc[2*WIDTH-1:WIDTH];
        r_c   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_hs.sv
// Directed bench for alu_hs at WIDTH=32.
// Expected values are hand-computed constants.
module tb_alu_hs;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   lat;
  logic rdy_seen;

  alu_hs_if #(.WIDTH(32)) bus ();

  alu_hs #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: no finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] flg();
    return {bus.z, bus.n, bus.v, bus.c};
  endfunction

  task automatic issue(logic [3:0] op,
                       logic [31:0] x,
                       logic [31:0] y);
    bus.in_valid = 1'b1;
    bus.csig     = op;
    bus.a        = x;
    bus.b        = y;
    tick();
    bus.in_valid = 1'b0;
    bus.a        = ~x;
    bus.b        = ~y;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic run(string tag,
                     logic [3:0] op,
                     logic [31:0] x,
                     logic [31:0] y,
                     logic [31:0] er,
                     logic [3:0] ef);
    issue(op, x, y);
    chk({tag, " valid"}, bus.out_valid, 1);
    chk({tag, " out"}, bus.out, er);
    chk({tag, " zvnc"}, flg(), ef);
    consume();
  endtask

  task automatic run_mul(string tag,
                         logic [31:0] x,
                         logic [31:0] y,
                         logic [31:0] er,
                         logic [3:0] ef);
    issue(4'd10, x, y);
    lat = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 33);
    chk({tag, " busy rdy"}, rdy_seen, 0);
    chk({tag, " out"}, bus.out, er);
    chk({tag, " zvnc"}, flg(), ef);
    consume();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a    = '0;
    bus.b    = '0;
    bus.csig = '0;
    tick();
    tick();
    chk("rst valid", bus.out_valid, 0);
    chk("rst out", bus.out, 0);
    chk("rst zvnc", flg(), 0);
    chk("rst rdy", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rst rdy hi", bus.in_ready, 1);

    run("add ovf", 4'd6, 32'h7FFF_FFFF, 32'h1,
        32'h8000_0000, 4'b0110);
    run("add cry", 4'd6, 32'hFFFF_FFFF, 32'h1,
        32'h0, 4'b1001);
    run("sub neg", 4'd5, 32'd5, 32'd7,
        32'hFFFF_FFFE, 4'b0101);
    run("sub zero", 4'd5, 32'd3, 32'd3,
        32'h0, 4'b1000);
    run("sub ovf", 4'd5, 32'h8000_0000, 32'h1,
        32'h7FFF_FFFF, 4'b0010);

    run_mul("mul big", 32'h0001_0000,
            32'h0001_0000, 32'h0, 4'b1010);
    run_mul("mul small", 32'h0001_2345,
            32'h0000_0100, 32'h0123_4500, 4'b0000);
    run_mul("mul ones", 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'h1, 4'b0010);

    run("sra", 4'd14, 32'h8000_0000, 32'h24,
        32'hF800_0000, 4'b0100);
    run("srl", 4'd4, 32'h8000_0000, 32'h24,
        32'h0800_0000, 4'b0000);
    run("sll", 4'd3, 32'h1, 32'h21,
        32'h2, 4'b0000);
    run("slt t", 4'd9, 32'hFFFF_FFFF, 32'h1,
        32'h1, 4'b0000);
    run("slt f", 4'd9, 32'h1, 32'hFFFF_FFFF,
        32'h0, 4'b1000);
    run("lwsw", 4'd13, 32'h100, 32'h10,
        32'h140, 4'b0000);
    run("lwsw wrap", 4'd13, 32'hFFFF_FFFF, 32'h1,
        32'h3, 4'b0000);
    run("clr", 4'd11, 32'h1234, 32'h5678,
        32'h0, 4'b1000);
    run("stf", 4'd12, 32'h0, 32'h0,
        32'hFFFF_FFFF, 4'b0100);
    run("nor", 4'd7, 32'h0, 32'h0,
        32'hFFFF_FFFF, 4'b0100);
    run("nand", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
        32'h0, 4'b1000);
    run("andn", 4'd15, 32'hF0F0, 32'hFF00,
        32'h00F0, 4'b0000);
    run("xor", 4'd2, 32'hAAAA, 32'hFFFF,
        32'h5555, 4'b0000);

    issue(4'd6, 32'd2, 32'd3);
    bus.in_valid = 1'b1;
    bus.csig = 4'd0;
    bus.a = 32'hF0;
    bus.b = 32'h0F;
    for (int i = 0; i < 5; i++) begin
      chk("bp out", bus.out, 32'd5);
      chk("bp rdy", bus.in_ready, 0);
      tick();
    end
    chk("bp valid", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("b2b valid", bus.out_valid, 1);
    chk("b2b out", bus.out, 32'hFF);
    tick();
    bus.out_ready = 1'b0;
    chk("drain valid", bus.out_valid, 0);
    chk("drain hold", bus.out, 32'hFF);

    run("and", 4'd1, 32'hF0F0, 32'hFF00,
        32'hF000, 4'b0000);
    issue(4'd10, 32'd3, 32'd5);
    for (int i = 0; i < 9; i++) tick();
    chk("mid rdy", bus.in_ready, 0);
    rst_n = 1'b0;
    tick();
    chk("mrst valid", bus.out_valid, 0);
    chk("mrst out", bus.out, 0);
    chk("mrst zvnc", flg(), 0);
    chk("mrst rdy lo", bus.in_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("mrst rdy hi", bus.in_ready, 1);
    for (int i = 0; i < 40; i++) tick();
    chk("mrst no out", bus.out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
